// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: valid/ready request and response channels
// in front of a combinational-read memory. Define LSU_STORE_ACK_EN to ack stores.
module load_store_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MEM_SIZE = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_idata,
  input  logic [WIDTH-1:0]      mem_odata,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_resp_data;
  logic [15:0]           r_op_count;
  logic                  w_op_done;

  // An operation completes on the response handshake, or when an unacked store leaves WRITE
`ifdef LSU_STORE_ACK_EN
  assign w_op_done = (r_state == RESP) && resp_ready;
`else
  assign w_op_done = (r_state == WRITE) || ((r_state == RESP) && resp_ready);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_op_done && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
`ifdef LSU_STORE_ACK_EN
          r_resp_data <= r_wdata;
          r_state     <= RESP;
`else
          r_state     <= IDLE;
`endif
        end
        READ: begin
          r_resp_data <= mem_odata;
          r_state     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them asynchronously
  assign req_ready  = (r_state == IDLE);
  assign mem_write  = (r_state == WRITE);
  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;
  assign mem_addr   = r_addr;
  assign mem_idata  = r_wdata;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a transaction-level memory model. Honours LSU_STORE_ACK_EN.
module tb_load_store_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_data;
  logic             mem_write;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_idata;
  logic [WIDTH-1:0] mem_odata;
  logic [15:0]      op_count;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  load_store_unit #(.WIDTH(WIDTH), .MEM_SIZE(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_idata(mem_idata),
    .mem_odata(mem_odata), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Memory attached to the unit: synchronous write, combinational read
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_idata;
  assign mem_odata = mem[mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Present one request in an IDLE cycle; returns at the negedge of the cycle after acceptance
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
  endtask

  // Called in the cycle after a store is accepted; leaves the unit IDLE
  task automatic finish_store();
    @(negedge clk);
`ifdef LSU_STORE_ACK_EN
    handshake();
`endif
    exp_ops++;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write !== 1'b0 || op_count !== 16'd0 ||
        resp_data !== '0 || mem_addr !== '0 || mem_idata !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b rv=%b mw=%b ops=%0d rd=%h ma=%0d mi=%h required 1 0 0 0 0 0 0",
               req_ready, resp_valid, mem_write, op_count, resp_data, mem_addr, mem_idata);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_store();
    issue(1'b1, 5'd5, 32'hDEADBEEF);
    ref_mem[5] = 32'hDEADBEEF;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 5'd5 || mem_idata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_write_cycle: mw=%b ma=%0d mi=%h rdy=%b required 1 5 deadbeef 0",
               mem_write, mem_addr, mem_idata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || mem[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_one_cycle: mw=%b mem5=%h required 0 deadbeef", mem_write, mem[5]);
    end
`ifdef LSU_STORE_ACK_EN
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || req_ready !== 1'b0) begin
      errors++; $display("FAIL store_ack: rv=%b rd=%h rdy=%b required 1 deadbeef 0", resp_valid, resp_data, req_ready);
    end
    handshake();
`else
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL store_ready_n2: rdy=%b rv=%b required 1 0", req_ready, resp_valid);
    end
`endif
    exp_ops++;
    checks++;
    if (op_count !== 16'(exp_ops)) begin
      errors++; $display("FAIL store_opcount: got %0d required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_store_load();
    issue(1'b1, 5'd31, 32'h1234);
    ref_mem[31] = 32'h1234;
    finish_store();
    issue(1'b0, 5'd31, 32'h0);
    checks++;
    if (resp_valid !== 1'b0 || mem_addr !== 5'd31) begin
      errors++; $display("FAIL load_n1: rv=%b ma=%0d required 0 31", resp_valid, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h1234) begin
      errors++; $display("FAIL load_n2: rv=%b rd=%h required 1 1234", resp_valid, resp_data);
    end
    handshake();
    exp_ops++;
    checks++;
    if (op_count !== 16'(exp_ops) || req_ready !== 1'b1) begin
      errors++; $display("FAIL load_done: ops=%0d rdy=%b required %0d 1", op_count, req_ready, exp_ops);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] v;
    v = $urandom;
    issue(1'b1, 5'd7, v);
    ref_mem[7] = v;
    finish_store();
    issue(1'b0, 5'd7, 32'h0);
    // Requests while busy must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = ~ref_mem[9];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== v || req_ready !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: rv=%b rd=%h rdy=%b mw=%b required 1 %h 0 0",
                 i, resp_valid, resp_data, req_ready, mem_write, v);
      end
    end
    req_valid = 1'b0;
    handshake();
    exp_ops++;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[9] !== ref_mem[9] || op_count !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL backpressure_after: rdy=%b rv=%b mem9=%h ops=%0d required 1 0 %h %0d",
               req_ready, resp_valid, mem[9], op_count, ref_mem[9], exp_ops);
    end
  endtask

`ifdef LSU_STORE_ACK_EN
  task automatic test_store_ack();
    issue(1'b1, 5'd3, 32'hA5A5A5A5);
    ref_mem[3] = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5A5A5 || op_count !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL ack_resp: rv=%b rd=%h ops=%0d required 1 a5a5a5a5 %0d", resp_valid, resp_data, op_count, exp_ops);
    end
    handshake();
    exp_ops++;
    checks++;
    if (op_count !== 16'(exp_ops)) begin
      errors++; $display("FAIL ack_opcount: got %0d required %0d", op_count, exp_ops);
    end
  endtask
`endif

  task automatic test_random();
    logic             we;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d, e;
    int               dly;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(1, 0));
      a  = AW'($urandom_range(DEPTH - 1, 0));
      d  = $urandom;
      if (we) begin
        issue(1'b1, a, d);
        ref_mem[a] = d;
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== a || mem_idata !== d) begin
          errors++;
          $display("FAIL rand_store[%0d]: mw=%b ma=%0d mi=%h required 1 %0d %h", n, mem_write, mem_addr, mem_idata, a, d);
        end
        finish_store();
      end else begin
        e = ref_mem[a];
        issue(1'b0, a, d);
        @(negedge clk);
        dly = $urandom_range(3, 0);
        for (int k = 0; k <= dly; k++) begin
          if (k > 0) @(negedge clk);
          checks++;
          if (resp_valid !== 1'b1 || resp_data !== e) begin
            errors++;
            $display("FAIL rand_load[%0d.%0d]: rv=%b rd=%h required 1 %h", n, k, resp_valid, resp_data, e);
          end
        end
        handshake();
        exp_ops++;
      end
      checks++;
      if (op_count !== 16'(exp_ops) || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ops[%0d]: ops=%0d rdy=%b required %0d 1", n, op_count, req_ready, exp_ops);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int K = 12;
    logic             q_we   [K];
    logic [AW-1:0]    q_addr [K];
    logic [WIDTH-1:0] q_data [K];
    logic [WIDTH-1:0] expq[$];
    int idx = 0, last_acc = -1, last_gap = 0, nresp = 0, nexp = 0;
    logic acc;
    for (int i = 0; i < K; i++) begin
      q_we[i]   = (i % 2 == 0);
      q_addr[i] = (i % 2 == 0) ? AW'(i + 10) : AW'(i + 9);
      q_data[i] = $urandom;
    end
    resp_ready = 1'b1;
    req_we = q_we[0]; req_addr = q_addr[0]; req_wdata = q_data[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = 1'b0;
      if (resp_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_extra_resp: cycle %0d got %h required none", cyc, resp_data);
        end else begin
          if (resp_data !== expq[0]) begin
            errors++; $display("FAIL b2b_resp: cycle %0d got %h required %h", cyc, resp_data, expq[0]);
          end
          void'(expq.pop_front());
          exp_ops++;
        end
        nresp++;
      end
      if (req_ready === 1'b1 && idx < K) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != last_gap) begin
            errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles required %0d", idx, cyc - last_acc, last_gap);
          end
        end
        if (q_we[idx]) begin
          ref_mem[q_addr[idx]] = q_data[idx];
`ifdef LSU_STORE_ACK_EN
          expq.push_back(q_data[idx]); nexp++; last_gap = 3;
`else
          exp_ops++; last_gap = 2;
`endif
        end else begin
          expq.push_back(ref_mem[q_addr[idx]]); nexp++; last_gap = 3;
        end
        last_acc = cyc; idx++; acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (idx < K) begin
          req_we = q_we[idx]; req_addr = q_addr[idx]; req_wdata = q_data[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checks++;
    if (idx != K || nresp != nexp || op_count !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL b2b_totals: accepted=%0d resp=%0d ops=%0d required %0d %0d %0d", idx, nresp, op_count, K, nexp, exp_ops);
    end
    for (int i = 0; i < K; i += 2) begin
      checks++;
      if (mem[q_addr[i]] !== ref_mem[q_addr[i]]) begin
        errors++; $display("FAIL b2b_mem[%0d]: got %h required %h", q_addr[i], mem[q_addr[i]], ref_mem[q_addr[i]]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 5'd12, ~ref_mem[12]);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL rst_write_setup: mw=%b required 1", mem_write);
    end
    #2 rst = 1'b1;
    #1;
    exp_ops = 0;
    checks++;
    if (mem_write !== 1'b0 || resp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 1'b1 || resp_data !== '0) begin
      errors++;
      $display("FAIL rst_async: mw=%b rv=%b ops=%0d rdy=%b rd=%h required 0 0 0 1 0",
               mem_write, resp_valid, op_count, req_ready, resp_data);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[12] !== ref_mem[12] || op_count !== 16'd0) begin
        errors++;
        $display("FAIL rst_discard[%0d]: rv=%b rdy=%b mem12=%h ops=%0d required 0 1 %h 0",
                 i, resp_valid, req_ready, mem[12], op_count, ref_mem[12]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = WIDTH'(i * 32'h01010101);
      ref_mem[i] = WIDTH'(i * 32'h01010101);
    end
    test_reset();
    test_store();
    test_store_load();
    test_backpressure();
`ifdef LSU_STORE_ACK_EN
    test_store_ack();
`endif
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits.
REQ-002 Parameter: MEM_SIZE, default 32, number of memory words; localparam ADDR_WIDTH = $clog2(MEM_SIZE) (5 at defaults).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  unit can accept a request.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  ADDR_WIDTH  word address.
REQ-009 Port: req_wdata  input  WIDTH  store data.
REQ-010 Port: resp_valid  output  1  response present.
REQ-011 Port: resp_ready  input  1  consumer accepts the response.
REQ-012 Port: resp_data  output  WIDTH  load result, or store echo when acks are enabled.
REQ-013 Port: mem_write  output  1  drives the memory write strobe.
REQ-014 Port: mem_addr  output  ADDR_WIDTH  drives the memory address.
REQ-015 Port: mem_idata  output  WIDTH  drives the memory write data.
REQ-016 Port: mem_odata  input  WIDTH  memory read data; combinational from mem_addr.
REQ-017 Port: op_count  output  16  completed-operation counter.

Function
REQ-018 FSM states: IDLE, WRITE, READ, RESP; the unit SHALL hold exactly one request at a time.
REQ-019 In IDLE the unit SHALL assert req_ready=1; in all other states req_ready=0.
REQ-020 On an edge with req_valid&&req_ready, the unit SHALL latch req_we/req_addr/req_wdata and go to WRITE if req_we=1, else READ.
REQ-021 In WRITE, mem_write=1 for exactly one cycle, with mem_addr/mem_idata taken from the latch; the memory commits at the end of that cycle.
REQ-022 mem_write SHALL be 0 in every state other than WRITE.
REQ-023 In READ, mem_addr = latched address; resp_data SHALL capture mem_odata at the end of that cycle, and the next state is RESP.
REQ-024 Load latency: accepted at edge N, resp_valid=1 during cycle N+2.
REQ-025 In RESP, resp_valid=1; resp_data SHALL stay stable until the edge with resp_ready=1, after which the state is IDLE.
REQ-026 resp_ready=1 in the first RESP cycle SHALL complete the response in one cycle; no bubbles beyond those implied by the FSM.
REQ-027 req_valid outside IDLE SHALL be ignored and SHALL NOT be latched.
REQ-028 Outside WRITE, mem_addr SHALL hold the latched address and mem_idata the latched data; these values are don't-care to memory.
REQ-029 op_count increments by 1 when a store leaves WRITE (acks disabled) or when a response completes; it saturates at 16'hFFFF and does not wrap.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, mem_write=0, resp_valid=0, resp_data=0, op_count=0, latched addr/data=0, independent of clk.
REQ-031 A reset during WRITE SHALL de-assert mem_write asynchronously; the in-flight request is discarded and no response is produced.
REQ-032 After rst falls, req_ready=1 in the first cycle.

Configuration
REQ-033 Macro LSU_STORE_ACK_EN defined: WRITE goes to RESP with resp_data = latched store data; stores complete through the response handshake (store latency to resp_valid = 2 cycles).
REQ-034 Macro LSU_STORE_ACK_EN undefined: WRITE returns directly to IDLE; stores produce no response; req_ready=1 again in cycle N+2.

Verification
REQ-035 Store addr=5, data=32'hDEADBEEF -> mem_write=1 for exactly one cycle with mem_addr=5 and mem_idata=32'hDEADBEEF; without the macro, req_ready=1 two cycles after acceptance.
REQ-036 Store 32'h1234 to addr 31, then load addr 31 -> resp_valid in cycle N+2 with resp_data=32'h1234.
REQ-037 Load with resp_ready=0 for 5 cycles, then 1 -> resp_valid and resp_data stable all 6 cycles; req_ready=0 throughout; IDLE afterward.
REQ-038 Assert rst mid-WRITE -> mem_write=0 in the same cycle; no response; op_count=0.
REQ-039 With LSU_STORE_ACK_EN defined, store 32'hA5A5A5A5 -> resp_valid with resp_data=32'hA5A5A5A5; op_count increments by 1 on the handshake.
REQ-040 Hold req_valid=1 continuously with alternating store/load traffic -> exactly one request accepted per FSM round trip; no request dropped or duplicated.
